// File: rtl/saph_vidrx_vga.sv
// saph_vidrx_vga: VGA timing receiver measuring h/v porch, sync and video widths with lock and pixel coordinates
// Ports: clk, rst_n (async active-low); pix_en qualifies every sample; hsync/vsync/de stream with
//   hsync_pol/vsync_pol (1 = active-high); h_*_width in ticks, v_*_width in lines; h_locked/v_locked;
//   pix_valid/pix_x/pix_y one strobe per active pixel; frame_start strobe on vsync activation.
module saph_vidrx_vga #(
  parameter int x_width = 9,
  parameter int y_width = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_en,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               de,
  input  logic               hsync_pol,
  input  logic               vsync_pol,
  output logic [x_width-1:0] h_fp_width,
  output logic [x_width-1:0] h_vid_width,
  output logic [x_width-1:0] h_bp_width,
  output logic [x_width-1:0] h_sync_width,
  output logic [y_width-1:0] v_fp_width,
  output logic [y_width-1:0] v_vid_width,
  output logic [y_width-1:0] v_bp_width,
  output logic [y_width-1:0] v_sync_width,
  output logic               h_locked,
  output logic               v_locked,
  output logic               pix_valid,
  output logic [x_width-1:0] pix_x,
  output logic [y_width-1:0] pix_y,
  output logic               frame_start
);
  // Low two bits of a non-idle state index its pending-width slot.
  localparam logic [2:0] H_SYNC = 3'd0, H_BP = 3'd1, H_VID = 3'd2, H_FP = 3'd3, H_IDLE = 3'd4;
  localparam logic [2:0] V_SYNC = 3'd0, V_BP = 3'd1, V_VID = 3'd2, V_FP = 3'd3, V_IDLE = 3'd4;
  logic [2:0] h_st, h_nxt, v_st, v_le_st, v_nxt;
  logic hs, vs, hs_p, vs_p, de_p, line_de;
  logic hs_rise, hs_fall, vs_rise, vs_fall, de_rise, de_fall;
  logic line_end, frame_end, pixel, vs_leave;
  logic [x_width-1:0] h_cnt, x_cnt;
  logic [y_width-1:0] v_cnt, v_le_cnt, y_cnt;
  logic [x_width-1:0] hp [4];
  logic [x_width-1:0] h_meas [4];
  logic [y_width-1:0] vp [4];
  logic [y_width-1:0] vp_le [4];
  logic [y_width-1:0] v_meas [4];
  logic [y_width-1:0] vp_nxt [4];
  assign hs = hsync ~^ hsync_pol;
  assign vs = vsync ~^ vsync_pol;
  assign hs_rise = hs && !hs_p;
  assign hs_fall = !hs && hs_p;
  assign vs_rise = vs && !vs_p;
  assign vs_fall = !vs && vs_p;
  assign de_rise = de && !de_p;
  assign de_fall = !de && de_p;
  assign line_end = hs_rise && h_st != H_IDLE;
  assign frame_end = vs_rise && v_st != V_IDLE;
  assign pixel = de && h_nxt == H_VID && v_st != V_IDLE;
  always_comb begin
    h_nxt = hs_rise ? H_SYNC :
            (h_st == H_SYNC && hs_fall) ? H_BP :
            (h_st == H_BP && de_rise) ? H_VID :
            (h_st == H_VID && de_fall) ? H_FP : h_st;
    h_meas = hp;
    if (h_st != H_IDLE) h_meas[h_st[1:0]] = h_cnt;
    // Line-end transitions credit the ending line to the state it was classified into.
    v_le_st = !line_end ? v_st :
              ((v_st == V_BP || v_st == V_VID) && line_de) ? V_VID :
              (v_st == V_VID) ? V_FP : v_st;
    v_le_cnt = (!line_end || v_st == V_IDLE) ? v_cnt :
               (v_le_st != v_st) ? y_width'(1) :
               (&v_cnt ? v_cnt : v_cnt + 1'b1);
    vp_le = vp;
    if (v_le_st != v_st) vp_le[v_st[1:0]] = v_cnt;
    v_meas = vp_le;
    v_meas[v_le_st[1:0]] = v_le_cnt;
    vs_leave = vs_fall && v_le_st == V_SYNC;
    v_nxt = vs_rise ? V_SYNC : vs_leave ? V_BP : v_le_st;
    vp_nxt = vp_le;
    if (vs_rise) vp_nxt = '{default: '0};
    else if (vs_leave) vp_nxt[0] = v_le_cnt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {hs_p, vs_p, de_p, line_de, h_locked, v_locked, pix_valid, frame_start} <= '0;
      h_st <= H_IDLE;
      v_st <= V_IDLE;
      {h_cnt, x_cnt, pix_x, h_fp_width, h_vid_width, h_bp_width, h_sync_width} <= '0;
      {v_cnt, y_cnt, pix_y, v_fp_width, v_vid_width, v_bp_width, v_sync_width} <= '0;
      hp <= '{default: '0};
      vp <= '{default: '0};
    end else begin
      pix_valid <= pix_en && pixel;
      frame_start <= pix_en && vs_rise;
      if (pix_en) begin
        hs_p <= hs;
        vs_p <= vs;
        de_p <= de;
        h_st <= h_nxt;
        h_cnt <= (hs_rise || h_nxt != h_st) ? x_width'(1) : (&h_cnt ? h_cnt : h_cnt + 1'b1);
        if (line_end) begin
          hp <= '{default: '0};
          h_sync_width <= h_meas[0];
          h_bp_width <= h_meas[1];
          h_vid_width <= h_meas[2];
          h_fp_width <= h_meas[3];
          h_locked <= h_meas[0] == h_sync_width && h_meas[1] == h_bp_width &&
                      h_meas[2] == h_vid_width && h_meas[3] == h_fp_width;
        end else if (h_nxt != h_st && h_st != H_IDLE) hp[h_st[1:0]] <= h_cnt;
        line_de <= !line_end && (line_de || (de && h_nxt == H_VID));
        v_st <= v_nxt;
        v_cnt <= (vs_rise || vs_leave) ? '0 : v_le_cnt;
        vp <= vp_nxt;
        if (frame_end) begin
          v_sync_width <= v_meas[0];
          v_bp_width <= v_meas[1];
          v_vid_width <= v_meas[2];
          v_fp_width <= v_meas[3];
          v_locked <= v_meas[0] == v_sync_width && v_meas[1] == v_bp_width &&
                      v_meas[2] == v_vid_width && v_meas[3] == v_fp_width;
        end
        y_cnt <= vs_rise ? '0 : (line_end && line_de) ? y_cnt + 1'b1 : y_cnt;
        x_cnt <= pixel ? x_cnt + 1'b1 : '0;
        if (pixel) begin
          pix_x <= x_cnt;
          pix_y <= y_cnt;
        end
      end
    end
endmodule

// File: tb/tb_saph_vidrx_vga.sv
// tb_saph_vidrx_vga: randomized frame-level stimulus with a line/frame reference model and pixel scoreboard
module tb_saph_vidrx_vga;
  logic clk = 0, rst_n = 0, pix_en = 0, hsync = 0, vsync = 0, de = 0, hsync_pol = 1, vsync_pol = 1;
  logic [8:0] h_fp_width, h_vid_width, h_bp_width, h_sync_width;
  logic [8:0] v_fp_width, v_vid_width, v_bp_width, v_sync_width;
  logic h_locked, v_locked, pix_valid, frame_start;
  logic [8:0] pix_x, pix_y;
  saph_vidrx_vga dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hsync(hsync), .vsync(vsync), .de(de),
    .hsync_pol(hsync_pol), .vsync_pol(vsync_pol),
    .h_fp_width(h_fp_width), .h_vid_width(h_vid_width), .h_bp_width(h_bp_width), .h_sync_width(h_sync_width),
    .v_fp_width(v_fp_width), .v_vid_width(v_vid_width), .v_bp_width(v_bp_width), .v_sync_width(v_sync_width),
    .h_locked(h_locked), .v_locked(v_locked), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  int fixed_gap = 1;
  int qx[$], qy[$];
  int mh[4], ml[4], mv[4], vc[4];
  int hl = 0, vl = 0, vy = 0, fs_exp = 0, fs_seen = 0;
  bit started = 0, armed = 0, prev_vs = 0;
  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  function automatic int sat(int a);
    return a > 511 ? 511 : a;
  endfunction
  function automatic bit all_zero();
    return !(|{h_fp_width, h_vid_width, h_bp_width, h_sync_width, v_fp_width, v_vid_width,
               v_bp_width, v_sync_width, h_locked, v_locked, pix_valid, pix_x, pix_y, frame_start});
  endfunction
  always @(negedge clk) if (rst_n) begin
    if (frame_start) fs_seen++;
    if (pix_valid) begin
      if (qx.size() == 0) chk("pix_unexpected", int'(pix_valid), 0);
      else begin
        chk("pix_x", int'(pix_x), qx.pop_front());
        chk("pix_y", int'(pix_y), qy.pop_front());
      end
    end
  end
  task automatic tick(bit h, bit v, bit d);
    int g;
    g = fixed_gap >= 0 ? fixed_gap : $urandom_range(0, 2);
    repeat (g) begin
      pix_en = 0;
      @(posedge clk);
      #1;
    end
    hsync = h ? hsync_pol : ~hsync_pol;
    vsync = v ? vsync_pol : ~vsync_pol;
    de = d;
    pix_en = 1;
    @(posedge clk);
    #1;
    pix_en = 0;
  endtask
  task automatic do_reset(int pending);
    @(negedge clk);
    #2;
    chk("pix_pending_at_rst", qx.size(), pending);
    qx.delete();
    qy.delete();
    rst_n = 0;
    #1;
    chk("outputs_zero_in_rst", int'(all_zero()), 1);
    repeat (2) @(posedge clk);
    #1;
    chk("outputs_zero_held", int'(all_zero()), 1);
    rst_n = 1;
    started = 0;
    armed = 0;
    prev_vs = 0;
    mh = '{0, 0, 0, 0};
    mv = '{0, 0, 0, 0};
    hl = 0;
    vl = 0;
    vy = 0;
  endtask
  // A line is sync s, back porch b, video slot v (de only on video lines), front porch f.
  task automatic run_line(int s, int b, int v, int f, bit vsh, bit dev, int rst_at);
    int m[4];
    bit vrise, eq;
    m[0] = sat(s);
    m[1] = sat(dev ? b : b + v + f);
    m[2] = dev ? sat(v) : 0;
    m[3] = dev ? sat(f) : 0;
    vrise = vsh && !prev_vs;
    prev_vs = vsh;
    tick(1, vsh, 0);
    if (started) begin
      eq = 1;
      for (int i = 0; i < 4; i++) if (ml[i] != mh[i]) eq = 0;
      hl = eq;
      mh = ml;
    end
    ml = m;
    started = 1;
    if (vrise) begin
      fs_exp++;
      if (armed) begin
        eq = 1;
        for (int i = 0; i < 4; i++) if (vc[i] != mv[i]) eq = 0;
        vl = eq;
        mv = vc;
      end
      armed = 1;
      vc = '{0, 0, 0, 0};
      vy = 0;
    end
    chk("h_sync_width", int'(h_sync_width), mh[0]);
    chk("h_bp_width", int'(h_bp_width), mh[1]);
    chk("h_vid_width", int'(h_vid_width), mh[2]);
    chk("h_fp_width", int'(h_fp_width), mh[3]);
    chk("h_locked", int'(h_locked), hl);
    chk("v_sync_width", int'(v_sync_width), mv[0]);
    chk("v_bp_width", int'(v_bp_width), mv[1]);
    chk("v_vid_width", int'(v_vid_width), mv[2]);
    chk("v_fp_width", int'(v_fp_width), mv[3]);
    chk("v_locked", int'(v_locked), vl);
    if (vsh) vc[0]++;
    else if (dev) vc[2]++;
    else if (vc[2] == 0) vc[1]++;
    else vc[3]++;
    if (dev && armed) begin
      for (int x = 0; x < v; x++) begin
        qx.push_back(x % 512);
        qy.push_back(vy % 512);
      end
      vy++;
    end
    for (int i = 1; i < s; i++) tick(1, vsh, 0);
    for (int i = 0; i < b; i++) tick(0, vsh, 0);
    for (int i = 0; i < v; i++) begin
      if (i == rst_at) do_reset(v - i);
      tick(0, vsh, dev);
    end
    for (int i = 0; i < f; i++) tick(0, vsh, 0);
  endtask
  // Frame: lines 0-1 vsync, 2 back porch, 3-7 video, 8-9 front porch.
  task automatic run_frame(int start, int kind);
    int s, b, v, f, ra;
    bit vsh, dev;
    for (int l = start; l < 10; l++) begin
      s = 4; b = 3; v = 16; f = 2; ra = -1;
      vsh = l < 2;
      dev = l >= 3 && l < 8;
      if (kind == 1 && l == 5) begin v = 15; f = 3; end
      if (kind == 2 && l == 5) begin v = 18; f = 0; end
      if (kind == 3 && l == 9) s = 600;
      if (kind == 4 && dev) begin
        s = $urandom_range(1, 6);
        b = $urandom_range(1, 4);
        v = $urandom_range(1, 20);
        f = $urandom_range(0, 4);
      end
      if (kind == 5 && l == 5) ra = $urandom_range(2, 12);
      run_line(s, b, v, f, vsh, dev, ra);
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_zero", int'(all_zero()), 1);
    rst_n = 1;
    run_frame(3, 0);
    run_frame(0, 0);
    run_frame(0, 0);
    run_frame(0, 0);
    fixed_gap = -1;
    hsync_pol = 0;
    vsync_pol = 0;
    run_frame(0, 0);
    run_frame(0, 1);
    run_frame(0, 2);
    run_frame(0, 3);
    hsync_pol = 1;
    vsync_pol = 1;
    run_frame(0, 4);
    run_frame(0, 0);
    run_frame(0, 5);
    run_frame(0, 0);
    run_frame(0, 0);
    run_frame(0, 0);
    run_line(4, 3, 16, 2, 1, 0, -1);
    repeat (4) @(posedge clk);
    #1;
    chk("pix_queue_drained", qx.size(), 0);
    chk("frame_start_count", fs_seen, fs_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
